// File: rtl/car_pos_ctrl.sv
// Player-car horizontal position controller: synchronised buttons, move FSM, tick divider,
// road-edge clamp with latched collision. Optional step acceleration under `CAR_ACCEL_EN`.
module car_pos_ctrl #(
    parameter int X_W         = 10,
    parameter int ROAD_LEFT   = 234,
    parameter int ROAD_RIGHT  = 400,
    parameter int CAR_W       = 14,
    parameter int X_INIT      = 300,
    parameter int STEP        = 1,
    parameter int MOVE_DIV    = 1000000,
    parameter int DIV_W       = 24,
    parameter int ACCEL_TICKS = 16,
    parameter int STEP_MAX    = 8
) (
    input  logic           clk,
    input  logic           BTNC,
    input  logic           BTNL,
    input  logic           BTNR,
    output logic [X_W-1:0] car_x,
    output logic           collided,
    output logic [1:0]     move_dir,
    output logic           step_tick
);
    // Encoding doubles as the move_dir output value.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LEFT  = 2'b01,
        S_RIGHT = 2'b10,
        S_CRASH = 2'b11
    } state_t;

    localparam logic [X_W:0]     RL       = (X_W+1)'(ROAD_LEFT);
    localparam logic [X_W:0]     RR       = (X_W+1)'(ROAD_RIGHT);
    localparam logic [X_W:0]     CW       = (X_W+1)'(CAR_W);
    localparam logic [X_W-1:0]   RL_X     = X_W'(ROAD_LEFT);
    localparam logic [X_W-1:0]   RC_X     = X_W'(ROAD_RIGHT - CAR_W);
    localparam logic [X_W-1:0]   INIT_X   = X_W'(X_INIT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);

    logic           l_s1_q, l_s2_q, r_s1_q, r_s2_q;
    state_t         state_q, state_d, want;
    logic [DIV_W-1:0] div_q, div_d;
    logic [X_W-1:0] x_q, x_d;
    logic           coll_q, coll_d;
    logic           tick_q, tick_d;
    logic           move_tick, moving;
    logic [X_W:0]   x_left, x_right, step;

    always_ff @(posedge clk or posedge BTNC) begin
        if (BTNC) begin
            l_s1_q <= 1'b0;
            l_s2_q <= 1'b0;
            r_s1_q <= 1'b0;
            r_s2_q <= 1'b0;
        end else begin
            l_s1_q <= BTNL;
            l_s2_q <= l_s1_q;
            r_s1_q <= BTNR;
            r_s2_q <= r_s1_q;
        end
    end

    always_comb begin
        want = S_IDLE;
        if (l_s2_q && !r_s2_q)      want = S_LEFT;
        else if (r_s2_q && !l_s2_q) want = S_RIGHT;
    end

    always_comb begin
        state_d   = state_q;
        div_d     = '0;
        x_d       = x_q;
        coll_d    = coll_q;
        tick_d    = 1'b0;
        moving    = (state_q == S_LEFT) || (state_q == S_RIGHT);
        move_tick = moving && (div_q == DIV_LAST);
        x_left    = {1'b0, x_q} - step;
        x_right   = {1'b0, x_q} + step;
        if (state_q != S_CRASH) state_d = want;
        if (move_tick) begin
            tick_d = 1'b1;
            if (state_q == S_LEFT) begin
                // Guard the subtraction so a large step cannot wrap past zero.
                if (({1'b0, x_q} >= step) && (x_left >= RL)) begin
                    x_d = x_left[X_W-1:0];
                end else begin
                    x_d     = RL_X;
                    coll_d  = 1'b1;
                    state_d = S_CRASH;
                end
            end else begin
                if ((x_right + CW) <= RR) begin
                    x_d = x_right[X_W-1:0];
                end else begin
                    x_d     = RC_X;
                    coll_d  = 1'b1;
                    state_d = S_CRASH;
                end
            end
        end
        // Any state change (including a direction flip) restarts the interval.
        if (moving && (state_d == state_q))
            div_d = move_tick ? '0 : div_q + DIV_W'(1);
    end

`ifdef CAR_ACCEL_EN
    localparam int           ACC_W    = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCEL_TICKS - 1);
    localparam logic [X_W:0] STEP_B   = (X_W+1)'(STEP);
    localparam logic [X_W:0] SMAX_B   = (X_W+1)'(STEP_MAX);

    logic [X_W:0]     step_q, step_d, step_dbl;
    logic [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        step_d   = step_q;
        acc_d    = acc_q;
        step_dbl = {step_q[X_W-1:0], 1'b0};
        if (!moving || (state_d != state_q)) begin
            step_d = STEP_B;
            acc_d  = '0;
        end else if (move_tick) begin
            if (acc_q == ACC_LAST) begin
                acc_d  = '0;
                step_d = (step_dbl > SMAX_B) ? SMAX_B : step_dbl;
            end else begin
                acc_d = acc_q + ACC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge BTNC) begin
        if (BTNC) begin
            step_q <= STEP_B;
            acc_q  <= '0;
        end else begin
            step_q <= step_d;
            acc_q  <= acc_d;
        end
    end

    assign step = step_q;
`else
    assign step = (X_W+1)'(STEP);
`endif

    always_ff @(posedge clk or posedge BTNC) begin
        if (BTNC) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            x_q     <= INIT_X;
            coll_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            x_q     <= x_d;
            coll_q  <= coll_d;
            tick_q  <= tick_d;
        end
    end

    assign car_x     = x_q;
    assign collided  = coll_q;
    assign move_dir  = state_q;
    assign step_tick = tick_q;
endmodule

// File: tb/tb_car_pos_ctrl.sv
// Bench for car_pos_ctrl: event-level position model compared every cycle, plus directed
// literal checks (reset, 10-tick move, both buttons, right wall, large-step clamp, accel).
module tb_car_pos_ctrl;
    localparam int X_W = 10;
    localparam int RL = 234, RR = 400, CW = 14, XI = 300, STP = 1, MD = 4;
    localparam int ACC_T = 2, SMAX = 4;

    logic clk = 1'b0, BTNC = 1'b0, BTNL = 1'b0, BTNR = 1'b0;
    logic [X_W-1:0] car_x, car_x2;
    logic collided, collided2, step_tick, step_tick2;
    logic [1:0] move_dir, move_dir2;

    int n_checks = 0, n_errors = 0;
    int cyc = 0, pulse_cnt = 0, last_pulse = -1, bad_gap = 0;
    int x_at86 = -1, c_at86 = -1;
    logic [X_W-1:0] exp_q[$];

    car_pos_ctrl #(.X_W(X_W), .ROAD_LEFT(RL), .ROAD_RIGHT(RR), .CAR_W(CW), .X_INIT(XI),
                   .STEP(STP), .MOVE_DIV(MD), .DIV_W(8), .ACCEL_TICKS(ACC_T),
                   .STEP_MAX(SMAX)) dut (
        .clk(clk), .BTNC(BTNC), .BTNL(BTNL), .BTNR(BTNR),
        .car_x(car_x), .collided(collided), .move_dir(move_dir), .step_tick(step_tick));

    car_pos_ctrl #(.X_W(X_W), .ROAD_LEFT(RL), .ROAD_RIGHT(RR), .CAR_W(CW), .X_INIT(236),
                   .STEP(3), .MOVE_DIV(MD), .DIV_W(8), .ACCEL_TICKS(ACC_T),
                   .STEP_MAX(SMAX)) dut2 (
        .clk(clk), .BTNC(BTNC), .BTNL(BTNL), .BTNR(BTNR),
        .car_x(car_x2), .collided(collided2), .move_dir(move_dir2), .step_tick(step_tick2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: buttons seen two edges late; a move every MD cycles spent in one direction.
    int m_x, m_dir, m_run, m_step, m_acc;
    bit m_coll, m_tick, l_d1, l_d2, r_d1, r_d2;
    always @(posedge clk or posedge BTNC) begin
        bit sl, sr;
        int want;
        if (BTNC) begin
            m_x = XI; m_dir = 0; m_run = 0; m_step = STP; m_acc = 0;
            m_coll = 0; m_tick = 0; l_d1 = 0; l_d2 = 0; r_d1 = 0; r_d2 = 0;
            exp_q.delete();
        end else begin
            sl = l_d2; sr = r_d2;
            l_d2 = l_d1; l_d1 = BTNL; r_d2 = r_d1; r_d1 = BTNR;
            m_tick = 0;
            if (!m_coll && m_dir != 0) begin
                m_run++;
                if (m_run % MD == 0) begin
                    m_tick = 1;
                    if (m_dir == 1) begin
                        if (m_x - m_step >= RL) m_x -= m_step;
                        else begin m_x = RL; m_coll = 1; end
                    end else begin
                        if (m_x + m_step + CW <= RR) m_x += m_step;
                        else begin m_x = RR - CW; m_coll = 1; end
                    end
                    exp_q.push_back(X_W'(m_x));
`ifdef CAR_ACCEL_EN
                    m_acc++;
                    if (m_acc == ACC_T) begin
                        m_acc = 0;
                        m_step = (2 * m_step > SMAX) ? SMAX : 2 * m_step;
                    end
`endif
                end
            end
            if (!m_coll) begin
                want = (sl && !sr) ? 1 : (sr && !sl) ? 2 : 0;
                if (want != m_dir) begin
                    m_dir = want; m_run = 0; m_step = STP; m_acc = 0;
                end
            end
        end
    end

    // Compare process: every cycle, 2 ns after the edge.
    always @(posedge clk) begin
        cyc++;
        #2;
        chk("car_x", car_x, m_x);
        chk("collided", collided, m_coll);
        chk("move_dir", move_dir, m_coll ? 3 : m_dir);
        chk("step_tick", step_tick, m_tick);
        if (step_tick) begin
            pulse_cnt++;
            if (last_pulse >= 0 && cyc - last_pulse != MD) bad_gap++;
            last_pulse = cyc;
            if (pulse_cnt == 86) begin x_at86 = car_x; c_at86 = collided; end
            if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
            else chk("sb_car_x", car_x, exp_q.pop_front());
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit l, input bit r);
        @(negedge clk);
        BTNL = l; BTNR = r;
    endtask

    task automatic clear_pulses();
        pulse_cnt = 0; last_pulse = -1; bad_gap = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        BTNC = 1'b1; BTNL = 1'b0; BTNR = 1'b0;
        wait_cyc(2);
        chk("rst_car_x", car_x, 300);
        chk("rst_collided", collided, 0);
        chk("rst_move_dir", move_dir, 0);
        chk("rst_step_tick", step_tick, 0);
        wait_cyc(3);
        BTNC = 1'b0;
        wait_cyc(1);
    endtask

    int x_after2;
    initial begin
        do_reset();

        // Ten ticks left: button sampled for 42 edges.
        clear_pulses();
        drive(1, 0);
        wait_cyc(20);
        chk("t2_move_dir", move_dir, 1);
        wait_cyc(22);
        BTNL = 1'b0;
        wait_cyc(8);
`ifdef CAR_ACCEL_EN
        x_after2 = 270;
`else
        x_after2 = 290;
`endif
        chk("t2_car_x", car_x, x_after2);
        chk("t2_pulses", pulse_cnt, 10);
        chk("t2_gaps", bad_gap, 0);
        chk("t2_idle", move_dir, 0);

        // Both buttons: no motion at all.
        clear_pulses();
        drive(1, 1);
        wait_cyc(100);
        chk("t3_car_x", car_x, x_after2);
        chk("t3_move_dir", move_dir, 0);
        chk("t3_pulses", pulse_cnt, 0);
        drive(0, 0);
        wait_cyc(4);

        // Right wall crash.
        do_reset();
        clear_pulses();
        drive(0, 1);
        wait_cyc(360);
        chk("t4_car_x", car_x, 386);
        chk("t4_collided", collided, 1);
        chk("t4_move_dir", move_dir, 3);
`ifndef CAR_ACCEL_EN
        chk("t4_pulses", pulse_cnt, 87);
        chk("t4_x86", x_at86, 386);
        chk("t4_c86", c_at86, 0);
`endif
        clear_pulses();
        drive(1, 0);
        wait_cyc(20);
        drive(0, 1);
        wait_cyc(20);
        chk("t4_frozen_x", car_x, 386);
        chk("t4_frozen_dir", move_dir, 3);
        chk("t4_frozen_pulses", pulse_cnt, 0);
        drive(0, 0);

        // Large step from 236 clamps at the left edge (second instance).
        do_reset();
        chk("t5_init", car_x2, 236);
        drive(1, 0);
        wait_cyc(20);
        chk("t5_car_x", car_x2, 234);
        chk("t5_collided", collided2, 1);
        chk("t5_move_dir", move_dir2, 3);

        // Reset while moving: immediate return, no residual tick.
        @(negedge clk);
        BTNC = 1'b1;
        #1;
        chk("t7_car_x", car_x, 300);
        chk("t7_step_tick", step_tick, 0);
        chk("t7_collided2", collided2, 0);
        BTNL = 1'b0;
        wait_cyc(3);
        BTNC = 1'b0;
        wait_cyc(12);
        chk("t7_still", car_x, 300);

        // Direction flips mid-interval (model-checked).
        drive(1, 0);
        wait_cyc(6);
        drive(0, 1);
        wait_cyc(13);
        drive(1, 0);
        wait_cyc(9);
        drive(0, 0);
        wait_cyc(8);

`ifdef CAR_ACCEL_EN
        do_reset();
        clear_pulses();
        drive(1, 0);
        wait_cyc(25);
        BTNL = 1'b0;
        wait_cyc(8);
        chk("t6_pulses", pulse_cnt, 6);
        chk("t6_car_x", car_x, 286);
`endif

        wait_cyc(4);
        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
